// File: rtl/wb_reg_bridge_pkg.sv
// wb_reg_bridge_pkg: FSM state type, default constants and counter sizing for the bridge
package wb_reg_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DRAIN} state_e;
  localparam int TMO_CYC_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
  localparam int CNT_W_DEF = $clog2(TMO_CYC_DEF + 1);
  function automatic int cnt_w(input int tmo);
    return $clog2(tmo + 1);
  endfunction
endpackage

// File: rtl/wb_reg_bridge.sv
// wb_reg_bridge: Wishbone-classic slave to single-outstanding register-bus master with timeout
module wb_reg_bridge
  import wb_reg_bridge_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          app_clk,
  input  logic          reset_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0] reg_rdata,
  input  logic          reg_ack,
  input  logic          reg_err,
  output logic          tmo_pulse
);
  localparam int CW = (cnt_w(TMO_CYC) > CNT_W_DEF) ? cnt_w(TMO_CYC) : cnt_w(TMO_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cs_q, cs_d, wr_q, wr_d, perr_q, perr_d, abort_q, abort_d, tmo_q, tmo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, dat_q, dat_d;
  logic [DW/8-1:0] be_q, be_d;
  logic done_ack, done_tmo, abort;
  // next-state: capture in IDLE, wait for ack or timeout in ACCESS, one response/drain cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cs_d = cs_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    dat_d = dat_q;
    perr_d = perr_q;
    abort_d = abort_q;
    tmo_d = 1'b0;
    done_ack = state_q == ACCESS && reg_ack;
    done_tmo = state_q == ACCESS && !reg_ack && cnt_q == TMO_LAST;
    abort = abort_q | ~wbs_cyc_i;
    case (state_q)
      IDLE: if (wbs_cyc_i && wbs_stb_i) begin
        state_d = ACCESS;
        cnt_d = '0;
        cs_d = 1'b1;
        wr_d = wbs_we_i;
        addr_d = wbs_adr_i;
        wdata_d = wbs_dat_i;
        be_d = wbs_sel_i;
        abort_d = 1'b0;
      end
      ACCESS: begin
        cnt_d = (reg_ack || cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        abort_d = abort;
        if (done_ack || done_tmo) begin
          state_d = abort ? DRAIN : RESP;
          cs_d = 1'b0;
          perr_d = done_ack ? reg_err : 1'b1;
          tmo_d = done_tmo;
          dat_d = abort ? dat_q : wr_q ? '0 : done_ack ? reg_rdata : ERR_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and request registers, cleared asynchronously
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cs_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      dat_q <= '0;
      perr_q <= 1'b0;
      abort_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cs_q <= cs_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      dat_q <= dat_d;
      perr_q <= perr_d;
      abort_q <= abort_d;
      tmo_q <= tmo_d;
    end
  end
  assign wbs_ack_o = state_q == RESP && !perr_q;
  assign wbs_err_o = state_q == RESP && perr_q;
  assign wbs_dat_o = dat_q;
  assign reg_cs = cs_q;
  assign reg_wr = wr_q;
  assign reg_addr = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_be = be_q;
  assign tmo_pulse = tmo_q;
endmodule

// File: doc/wb_reg_bridge.md
Name: wb_reg_bridge

Overview:
- Wishbone-classic slave to single-outstanding register-bus master bridge.
- Sits directly upstream of the SSPI/I2C peripheral wrapper and drives its reg_slv_* request bus (cs/wr/addr/wdata/be), consuming rdata/ack/err.
- Registers all request fields, so interconnect address decode never combines with the target's block-select and ack paths.
- Adds a bounded-wait timeout so a dead target cannot hang the Wishbone bus.

Parameters:
- AW, 11, register-bus address width (byte address).
- DW, 32, data width.
- TMO_CYC, 255, maximum ACCESS cycles without reg_ack before the bridge forces an error response; legal range 2..65535.
- ERR_DATA, 32'hFFFF_FFFF, value returned on wbs_dat_o for a timed-out read.

Ports:
- app_clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_adr_i  in  AW  byte address.
- wbs_we_i  in  1  write enable.
- wbs_dat_i  in  DW  write data.
- wbs_sel_i  in  DW/8  byte select.
- wbs_dat_o  out  DW  read data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_err_o  out  1  one-cycle error; mutually exclusive with wbs_ack_o.
- reg_cs  out  1  register request, held until reg_ack.
- reg_wr  out  1  1 = write.
- reg_addr  out  AW  registered address.
- reg_wdata  out  DW  registered write data.
- reg_be  out  DW/8  registered byte enables.
- reg_rdata  in  DW  target read data, valid with reg_ack.
- reg_ack  in  1  target acknowledge.
- reg_err  in  1  target error, valid with reg_ack.
- tmo_pulse  out  1  one-cycle timeout event for the status/interrupt block.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, timeout counter=0.
  - reg_cs, reg_wr, reg_addr, reg_wdata, reg_be all 0.
  - wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, tmo_pulse=0.
- FSM states: IDLE, ACCESS, RESP, DRAIN.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, capture adr/dat/we/sel into the reg_* output registers, set reg_cs=1, clear the counter, go to ACCESS.
  - reg_cs rises on the edge after stb is sampled: one cycle of request latency.
- ACCESS:
  - reg_cs held high; all request fields held stable.
  - The counter increments each cycle reg_ack=0.
  - On reg_ack=1:
    - reg_cs=0 at the next edge.
    - If reg_wr=0, latch reg_rdata into wbs_dat_o; otherwise wbs_dat_o=0.
    - Latch reg_err into a pending-error flag.
    - Go to RESP, or to DRAIN if wbs_cyc_i has dropped.
  - When the counter reaches TMO_CYC-1 with reg_ack=0:
    - reg_cs=0.
    - wbs_dat_o=ERR_DATA for reads, 0 for writes.
    - Pending error=1, tmo_pulse=1 for one cycle.
    - Go to RESP.
  - reg_ack and timeout in the same cycle: reg_ack wins, no tmo_pulse.
- RESP:
  - Assert exactly one of wbs_ack_o (pending error=0) or wbs_err_o (pending error=1) for one cycle, then go to IDLE.
  - The minimum request-to-ack latency is therefore 3 cycles plus target latency.
- Master abort (wbs_cyc_i drops during ACCESS):
  - The register access is not aborted; the bridge waits for reg_ack or timeout.
  - It then passes through DRAIN for one cycle with no wbs_ack_o/wbs_err_o, then goes to IDLE.
  - wbs_dat_o is not updated on an abort.
- Back-to-back accesses: a new request is accepted only in IDLE; the IDLE cycle after RESP is mandatory.
- reg_ack or reg_err seen while reg_cs=0 (IDLE, RESP, DRAIN) is ignored.
- Counter width is clog2(TMO_CYC+1); it saturates and never wraps.
- wbs_dat_o holds its last value outside RESP.

Decomposition:
- Shared package wb_reg_bridge_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, DRAIN);
  - the default TMO_CYC and ERR_DATA constants;
  - the localparam for counter width.
- There is no natural sub-module: the FSM, capture registers and timeout counter live in one module, within the 150–250 line RTL budget.

Test Plan:
- Write to 0x044, data 0xA5A5_1234, sel 4'hF; target acks 2 cycles after reg_cs → reg_cs high exactly 3 cycles with reg_wr=1, reg_addr=0x044, reg_be=4'hF; one wbs_ack_o, wbs_err_o=0.
- Read from 0x080; target returns 0x0000_005C with reg_ack 1 cycle after reg_cs → wbs_dat_o=0x0000_005C in the wbs_ack_o cycle; total latency 4 cycles from stb.
- Read with target never acking, TMO_CYC=8 → reg_cs drops after 8 cycles; tmo_pulse 1 cycle; wbs_err_o 1 cycle with wbs_dat_o=0xFFFF_FFFF; no wbs_ack_o.
- Target returns reg_ack=1 with reg_err=1 → wbs_err_o=1 for one cycle, wbs_ack_o stays 0, tmo_pulse=0.
- Master drops wbs_cyc_i 1 cycle into ACCESS; target acks 5 cycles later → reg_cs held until reg_ack; no wbs_ack_o/wbs_err_o; next request accepted normally.
- Assert reset_n low mid-ACCESS → reg_cs, wbs_ack_o and tmo_pulse go to 0 immediately (asynchronous); after release, state=IDLE and a fresh write completes normally.
